// File: rtl/fifo_burst_reader.sv
// Burst reader for a non-prefetch FIFO: pulls fixed or timed-out partial bursts and re-streams them via a skid FIFO.
// Optional sticky protocol-error flag is built when FBR_ERR_CHK_EN is defined.
module fifo_burst_reader #(
    parameter int DATA_W     = 32,
    parameter int LVL_W      = 11,
    parameter int BURST_LEN  = 16,
    parameter int SKID_DEPTH = 4,
    parameter int TIMEOUT    = 255
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              enable,
    output logic              fifo_rd_en,
    input  logic [DATA_W-1:0] fifo_rd_data,
    input  logic              fifo_rd_vld,
    input  logic              fifo_empty,
    input  logic [LVL_W-1:0]  fifo_rd_level,
    output logic [DATA_W-1:0] m_data,
    output logic              m_valid,
    output logic              m_last,
    input  logic              m_ready,
    output logic              busy,
    output logic [15:0]       burst_cnt,
    output logic              err
);

    // Handshake: a beat transfers on every cycle where m_valid and m_ready are both high;
    // m_data/m_last never change while m_valid is high and m_ready is low.

    localparam int PTR_W = $clog2(SKID_DEPTH);
    localparam int CNT_W = $clog2(SKID_DEPTH + 1);
    localparam int TMR_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

    localparam logic [LVL_W-1:0] BURST_LVL = LVL_W'(BURST_LEN);
    localparam logic [LVL_W-1:0] LVL_ONE   = LVL_W'(1);
    localparam logic [TMR_W-1:0] TMR_MAX   = TMR_W'(TIMEOUT);
    localparam logic [CNT_W-1:0] SKID_FULL = CNT_W'(SKID_DEPTH);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
    localparam logic [PTR_W-1:0] PTR_LAST  = PTR_W'(SKID_DEPTH - 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_BURST,
        ST_DRAIN
    } state_e;

    state_e             state_q, state_d;
    logic [LVL_W-1:0]   beats_q, beats_d;
    logic [LVL_W-1:0]   out_left_q, out_left_d;
    logic [CNT_W-1:0]   outst_q, outst_d;
    logic [CNT_W-1:0]   skid_cnt_q, skid_cnt_d;
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [TMR_W-1:0]   timer_q, timer_d;
    logic [15:0]        burst_cnt_q, burst_cnt_d;
    logic [DATA_W-1:0]  skid_mem [SKID_DEPTH];

    logic pop, push, vld_ok;

    // Credit check counts in-flight reads plus buffered words, so the skid can never overflow.
    assign fifo_rd_en = (state_q == ST_BURST) && (beats_q != '0) && !fifo_empty &&
                        (({1'b0, outst_q} + {1'b0, skid_cnt_q}) < {1'b0, SKID_FULL});

    assign m_valid   = (skid_cnt_q != '0);
    assign m_data    = m_valid ? skid_mem[rd_ptr_q] : '0;
    assign m_last    = m_valid && (out_left_q == LVL_ONE);
    assign busy      = (state_q != ST_IDLE);
    assign burst_cnt = burst_cnt_q;

    assign pop    = m_valid && m_ready;
    assign vld_ok = fifo_rd_vld && (outst_q != '0);
    assign push   = vld_ok && ((skid_cnt_q != SKID_FULL) || pop);

    always_comb begin
        outst_d    = outst_q;
        skid_cnt_d = skid_cnt_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        if (fifo_rd_en && !vld_ok) outst_d = outst_q + CNT_ONE;
        if (!fifo_rd_en && vld_ok) outst_d = outst_q - CNT_ONE;
        if (push && !pop) skid_cnt_d = skid_cnt_q + CNT_ONE;
        if (pop && !push) skid_cnt_d = skid_cnt_q - CNT_ONE;
        if (push) wr_ptr_d = (wr_ptr_q == PTR_LAST) ? '0 : wr_ptr_q + PTR_W'(1);
        if (pop)  rd_ptr_d = (rd_ptr_q == PTR_LAST) ? '0 : rd_ptr_q + PTR_W'(1);
    end

    always_comb begin
        state_d     = state_q;
        beats_d     = beats_q;
        out_left_d  = pop ? out_left_q - LVL_ONE : out_left_q;
        timer_d     = '0;
        burst_cnt_d = burst_cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (enable && (fifo_rd_level != '0) && (fifo_rd_level < BURST_LVL))
                    timer_d = (timer_q == TMR_MAX) ? timer_q : timer_q + TMR_W'(1);
                if (enable && (fifo_rd_level >= BURST_LVL)) begin
                    state_d    = ST_BURST;
                    beats_d    = BURST_LVL;
                    out_left_d = BURST_LVL;
                end else if (enable && (TIMEOUT != 0) && (fifo_rd_level != '0) &&
                             (timer_q == TMR_MAX)) begin
                    state_d    = ST_BURST;
                    beats_d    = fifo_rd_level;
                    out_left_d = fifo_rd_level;
                end
            end
            ST_BURST: begin
                if (fifo_rd_en) begin
                    beats_d = beats_q - LVL_ONE;
                    if (beats_q == LVL_ONE) state_d = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (pop && (out_left_q == LVL_ONE)) begin
                    state_d     = ST_IDLE;
                    burst_cnt_d = burst_cnt_q + 16'd1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            beats_q     <= '0;
            out_left_q  <= '0;
            outst_q     <= '0;
            skid_cnt_q  <= '0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            timer_q     <= '0;
            burst_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            beats_q     <= beats_d;
            out_left_q  <= out_left_d;
            outst_q     <= outst_d;
            skid_cnt_q  <= skid_cnt_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            timer_q     <= timer_d;
            burst_cnt_q <= burst_cnt_d;
        end
    end

    // Storage needs no reset: the head is masked by m_valid.
    always_ff @(posedge clk) begin
        if (push) skid_mem[wr_ptr_q] <= fifo_rd_data;
    end

`ifdef FBR_ERR_CHK_EN
    logic err_q;
    always_ff @(posedge clk) begin
        if (!rst_n)
            err_q <= 1'b0;
        else if ((fifo_rd_vld && (outst_q == '0)) ||
                 (vld_ok && (skid_cnt_q == SKID_FULL) && !pop))
            err_q <= 1'b1;
    end
    assign err = err_q;
`else
    assign err = 1'b0;
`endif

endmodule
